// File: rtl/fetch_issue.sv
// fetch_issue: front-end stage ahead of the ALU.
//   Fetches 32-bit instructions over a req/ack port and decodes them into
//   opcode/A/B/val/cin/rd. Reads a 16x32 register file and issues to the ALU
//   over a valid/ready handshake. Owns the PC, takes redirects (pc_load) and
//   register writeback (wb_*).
// Ports:
//   clkout, rst_n          clock (rising edge), async active-low reset
//   imem_req/addr/ack/data instruction fetch port (req held until ack)
//   iss_valid/iss_ready    issue handshake to the ALU
//   opcode, A, B, val, cin, rd   decoded issue payload
//   flag_c                 ALU carry flag, sampled at decode
//   wb_en/wb_addr/wb_data  register writeback (reg 0 is hardwired to zero)
//   pc_load/pc_new         PC redirect, overrides the fetch/issue sequence
// Build option:
//   FETCH_ISSUE_BYPASS_EN  forward wb_data into A/B when the decode cycle
//                          reads the register being written; otherwise
//                          decode waits one cycle and re-reads the file.
module fetch_issue #(
  parameter int DATA_SIZE = 32,
  parameter int IPTR_SIZE = 4,
  parameter int REG_AW    = 4
) (
  input  logic                 clkout,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [IPTR_SIZE-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_data,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [7:0]           opcode,
  output logic [DATA_SIZE-1:0] A,
  output logic [DATA_SIZE-1:0] B,
  output logic [DATA_SIZE-1:0] val,
  output logic                 cin,
  output logic [REG_AW-1:0]    rd,
  input  logic                 flag_c,
  input  logic                 wb_en,
  input  logic [REG_AW-1:0]    wb_addr,
  input  logic [DATA_SIZE-1:0] wb_data,
  input  logic                 pc_load,
  input  logic [IPTR_SIZE-1:0] pc_new
);

  typedef enum logic [1:0] {S_REQ, S_DEC, S_ISS} state_t;

  state_t                 state, state_nx;
  logic [IPTR_SIZE-1:0]   pc;
  logic [31:0]            ir;
  logic [DATA_SIZE-1:0]   regs [2**REG_AW];

  logic [REG_AW-1:0]      ra, rb;
  logic                   fetch_acc, iss_hs;
  logic                   hz_a, hz_b, stall;
  logic [DATA_SIZE-1:0]   rd_a, rd_b;

  function automatic logic [DATA_SIZE-1:0] sext_imm(input logic [13:0] imm);
    return {{(DATA_SIZE-14){imm[13]}}, imm};
  endfunction

  assign imem_addr = pc;
  assign ra        = ir[18 +: REG_AW];
  assign rb        = ir[14 +: REG_AW];

  // Only an ack answering a live request counts; this also drops any
  // response that was in flight across a reset.
  assign fetch_acc = (state == S_REQ) && imem_req && imem_ack;
  assign iss_hs    = iss_valid && iss_ready;

  assign hz_a = wb_en && (wb_addr != '0) && (wb_addr == ra);
  assign hz_b = wb_en && (wb_addr != '0) && (wb_addr == rb);

`ifdef FETCH_ISSUE_BYPASS_EN
  assign stall = 1'b0;
  assign rd_a  = hz_a ? wb_data : regs[ra];
  assign rd_b  = hz_b ? wb_data : regs[rb];
`else
  // Hold decode until the write has landed in the file.
  assign stall = (state == S_DEC) && (hz_a || hz_b);
  assign rd_a  = regs[ra];
  assign rd_b  = regs[rb];
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_REQ:   if (fetch_acc) state_nx = S_DEC;
      S_DEC:   if (!stall) state_nx = (ir[31:26] == 6'd0) ? S_REQ : S_ISS;
      S_ISS:   if (iss_hs) state_nx = S_REQ;
      default: state_nx = S_REQ;
    endcase
    if (pc_load) state_nx = S_REQ;
  end

  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= '0;
      imem_req  <= 1'b0;
      iss_valid <= 1'b0;
      opcode    <= '0;
      A         <= '0;
      B         <= '0;
      val       <= '0;
      cin       <= 1'b0;
      rd        <= '0;
    end else begin
      state <= state_nx;
      // A redirect drops the request for one cycle before fetching at pc_new.
      imem_req <= !pc_load && (state_nx == S_REQ);
      if (pc_load) begin
        pc        <= pc_new;
        iss_valid <= 1'b0;
      end else begin
        if (fetch_acc) pc <= pc + 1'b1;
        if (state == S_DEC && !stall) begin
          opcode    <= {2'b00, ir[31:26]};
          A         <= rd_a;
          B         <= rd_b;
          val       <= sext_imm(ir[13:0]);
          cin       <= flag_c;
          rd        <= ir[22 +: REG_AW];
          iss_valid <= (ir[31:26] != 6'd0);
        end else if (iss_hs) begin
          iss_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clkout) begin
    if (fetch_acc && !pc_load) ir <= imem_data;
  end

  // Entry 0 is never written, so reads of register 0 return zero.
  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_fetch_issue.sv
module tb_fetch_issue;

  logic        clkout = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        iss_valid;
  logic        iss_ready;
  logic [7:0]  opcode;
  logic [31:0] A, B, val;
  logic        cin;
  logic [3:0]  rd;
  logic        flag_c;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        pc_load;
  logic [3:0]  pc_new;

  int n_total = 0;
  int n_pass  = 0;

  // Reference state: architectural PC and register contents.
  logic [3:0]  mpc;
  logic [31:0] mreg [16];

  fetch_issue dut (
    .clkout(clkout), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .opcode(opcode), .A(A), .B(B), .val(val), .cin(cin), .rd(rd),
    .flag_c(flag_c), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_load(pc_load), .pc_new(pc_new)
  );

  always #5 clkout = ~clkout;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clkout);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input logic [13:0] imm);
    return {op, d, a, b, imm};
  endfunction

  function automatic logic [31:0] m_sext(input logic [13:0] imm);
    int v;
    v = int'(imm);
    if (v >= 8192) v = v - 16384;
    return 32'(v);
  endfunction

  task automatic model_reset();
    mpc = 4'd0;
    for (int i = 0; i < 16; i++) mreg[i] = 32'd0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", imem_req, 1'b1);
  endtask

  // One instruction through fetch, decode and issue. Optional writeback in the
  // decode cycle (hz*); iss_ready held low for wait_n cycles before accepting.
  task automatic do_fetch(input logic [31:0] ins, input int wait_n, input logic hz,
                          input logic [3:0] hza, input logic [31:0] hzd, input logic fc);
    logic [5:0]  op;
    logic [3:0]  ra, rb;
    logic        stall;
    logic [31:0] eA, eB;
    logic [3:0]  wa;
    logic [31:0] wd;
    op = ins[31:26];
    ra = ins[21:18];
    rb = ins[17:14];
    wait_req();
    check("fetch_addr", imem_addr, mpc);
    imem_ack  = 1'b1;
    imem_data = ins;
    flag_c    = fc;
    tick();
    imem_ack  = 1'b0;
    imem_data = $urandom;
    mpc = mpc + 4'd1;
    check("dec_valid", iss_valid, 1'b0);
    check("dec_req", imem_req, 1'b0);
    if (hz) begin
      wb_en = 1'b1; wb_addr = hza; wb_data = hzd;
    end
    tick();
    wb_en = 1'b0;
    stall = 1'b0;
    if (hz) begin
      if (hza != 4'd0) mreg[hza] = hzd;
`ifndef FETCH_ISSUE_BYPASS_EN
      stall = (hza != 4'd0) && (hza == ra || hza == rb);
`endif
    end
    if (stall) begin
      check("hz_stall_valid", iss_valid, 1'b0);
      tick();
    end
    if (op == 6'd0) begin
      check("bubble_valid", iss_valid, 1'b0);
      check("bubble_req", imem_req, 1'b1);
      check("bubble_addr", imem_addr, mpc);
      return;
    end
    eA = mreg[ra];
    eB = mreg[rb];
    check("iss_valid", iss_valid, 1'b1);
    check("opcode", opcode, {26'd0, op});
    check("A", A, eA);
    check("B", B, eB);
    check("val", val, m_sext(ins[13:0]));
    check("rd", rd, ins[25:22]);
    check("cin", cin, fc);
    for (int w = 0; w < wait_n; w++) begin
      // Writes during the stall must not disturb the held operands.
      wa = 4'($urandom_range(0, 15));
      wd = $urandom;
      wb_en = 1'b1; wb_addr = wa; wb_data = wd;
      tick();
      wb_en = 1'b0;
      if (wa != 4'd0) mreg[wa] = wd;
      check("hold_valid", iss_valid, 1'b1);
      check("hold_req", imem_req, 1'b0);
      check("hold_pc", imem_addr, mpc);
      check("hold_A", A, eA);
      check("hold_B", B, eB);
      check("hold_opcode", opcode, {26'd0, op});
    end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check("post_hs_valid", iss_valid, 1'b0);
    check("post_hs_req", imem_req, 1'b1);
    check("post_hs_addr", imem_addr, mpc);
  endtask

  task automatic do_load(input logic [3:0] target);
    pc_load = 1'b1;
    pc_new  = target;
    tick();
    pc_load = 1'b0;
    check("load_req_low", imem_req, 1'b0);
    check("load_valid", iss_valid, 1'b0);
    tick();
    check("load_req", imem_req, 1'b1);
    check("load_addr", imem_addr, target);
    mpc = target;
  endtask

  initial begin
    logic [5:0]  op;
    logic [3:0]  r_a;
    logic [31:0] ins;
    logic        hz;
    logic [3:0]  hza;

    rst_n = 1'b1;
    imem_ack = 1'b0; imem_data = 32'd0; iss_ready = 1'b0; flag_c = 1'b0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'd0; pc_load = 1'b0; pc_new = 4'd0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clkout);
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", iss_valid, 1'b0);
    check("rst_addr", imem_addr, 4'd0);
    check("rst_opcode", opcode, 8'd0);
    check("rst_A", A, 32'd0);

    // Ack held high from release; ready always high.
    rst_n = 1'b1; imem_ack = 1'b1; imem_data = 32'h04A1_4005; iss_ready = 1'b1;
    tick();
    check("t1_req", imem_req, 1'b1);
    check("t1_addr0", imem_addr, 4'd0);
    check("t1_valid0", iss_valid, 1'b0);
    tick();
    check("t1_dec_valid", iss_valid, 1'b0);
    tick();
    check("t1_iss_valid", iss_valid, 1'b1);
    check("t1_opcode", opcode, 8'h01);
    check("t1_val", val, 32'd5);
    check("t1_rd", rd, 4'd2);
    tick();
    check("t1_post_valid", iss_valid, 1'b0);
    check("t1_addr1", imem_addr, 4'd1);
    imem_ack = 1'b0; iss_ready = 1'b0;
    mpc = 4'd1;

    // Sign extension boundaries.
    do_fetch(enc(6'd3, 4'd1, 4'd0, 4'd0, 14'h3FFF), 0, 1'b0, 4'd0, 32'd0, 1'b1);
    do_fetch(enc(6'd4, 4'd1, 4'd0, 4'd0, 14'h2000), 0, 1'b0, 4'd0, 32'd0, 1'b0);
    do_fetch(enc(6'd5, 4'd1, 4'd0, 4'd0, 14'h1FFF), 0, 1'b0, 4'd0, 32'd0, 1'b0);

    // Preload the register file, including an ignored write to reg 0.
    for (int r = 0; r < 16; r++) begin
      wb_en = 1'b1; wb_addr = 4'(r); wb_data = $urandom;
      tick();
      if (r != 0) mreg[r] = wb_data;
    end
    wb_en = 1'b0;

    // Issue stall with iss_ready low for 4 cycles.
    do_fetch(enc(6'd7, 4'd3, 4'd4, 4'd9, 14'd100), 4, 1'b0, 4'd0, 32'd0, 1'b1);

    // PC wrap, then redirect colliding with an ack.
    do_load(4'd15);
    do_fetch(enc(6'd2, 4'd5, 4'd6, 4'd7, 14'd1), 0, 1'b0, 4'd0, 32'd0, 1'b0);
    check("wrap_pc", imem_addr, 4'd0);
    wait_req();
    imem_ack = 1'b1; imem_data = enc(6'd9, 4'd1, 4'd1, 4'd1, 14'd1);
    pc_load = 1'b1; pc_new = 4'd9;
    tick();
    imem_ack = 1'b0; pc_load = 1'b0;
    check("ld_ack_req", imem_req, 1'b0);
    check("ld_ack_valid", iss_valid, 1'b0);
    tick();
    check("ld_ack_addr", imem_addr, 4'd9);
    check("ld_ack_noissue", iss_valid, 1'b0);
    mpc = 4'd9;

    // Redirect in the same cycle as an accepted issue.
    wait_req();
    imem_ack = 1'b1; imem_data = enc(6'd1, 4'd2, 4'd3, 4'd4, 14'd7);
    tick();
    imem_ack = 1'b0;
    tick();
    check("ldhs_valid", iss_valid, 1'b1);
    iss_ready = 1'b1; pc_load = 1'b1; pc_new = 4'd3;
    tick();
    iss_ready = 1'b0; pc_load = 1'b0;
    check("ldhs_valid_low", iss_valid, 1'b0);
    check("ldhs_req_low", imem_req, 1'b0);
    tick();
    check("ldhs_addr", imem_addr, 4'd3);
    mpc = 4'd3;

    // Writeback hazard on ra in the decode cycle, then a write to reg 0.
    do_fetch(32'h04A1_4005, 0, 1'b1, 4'd8, 32'hDEAD_BEEF, 1'b0);
    do_fetch(enc(6'd1, 4'd2, 4'd0, 4'd5, 14'd5), 0, 1'b1, 4'd0, 32'h1234_5678, 1'b0);
    check("r0_model", mreg[0], 32'd0);
    do_fetch(enc(6'd6, 4'd2, 4'd3, 4'd11, 14'd5), 1, 1'b1, 4'd11, 32'hCAFE_0001, 1'b1);

    // Randomized instruction stream.
    for (int k = 0; k < 40; k++) begin
      op  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      r_a = 4'($urandom_range(0, 15));
      ins = enc(op, 4'($urandom_range(0, 15)), r_a, 4'($urandom_range(0, 15)),
                14'($urandom_range(0, 16383)));
      hz  = (op != 6'd0) && ($urandom_range(0, 1) == 1);
      hza = ($urandom_range(0, 1) == 1) ? r_a : 4'($urandom_range(0, 15));
      do_fetch(ins, $urandom_range(0, 3), hz, hza, $urandom, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while an issue is pending.
    wait_req();
    imem_ack = 1'b1; imem_data = enc(6'd12, 4'd1, 4'd2, 4'd3, 14'd9);
    tick();
    tick();
    check("rst6_pre_valid", iss_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst6_valid", iss_valid, 1'b0);
    check("rst6_req", imem_req, 1'b0);
    check("rst6_opcode", opcode, 8'd0);
    check("rst6_addr", imem_addr, 4'd0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    imem_ack = 1'b0;
    check("rst6_restart_req", imem_req, 1'b1);
    check("rst6_restart_addr", imem_addr, 4'd0);
    check("rst6_no_issue", iss_valid, 1'b0);
    do_fetch(enc(6'd8, 4'd4, 4'd2, 4'd3, 14'd1), 0, 1'b0, 4'd0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
